load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter DEPTH_LOG2, default 10, log2 of the data memory word count; sets the used word-index bits.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL provide port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port req_funct3  input  3  RV32I width/sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-008 SHALL provide port req_addr  input  32  byte address.
REQ-009 SHALL provide port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL provide port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-012 SHALL provide port rsp_err  output  1  request rejected; qualified by rsp_valid.
REQ-013 SHALL provide port mem_we  output  1  word write enable to data memory.
REQ-014 SHALL provide port mem_addr  output  32  word index: req_addr[DEPTH_LOG2+1:2], zero-extended.
REQ-015 SHALL provide port mem_wd  output  32  word write data.
REQ-016 SHALL provide port mem_rd  input  32  combinational word read data for mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE: req_valid=1 SHALL latch we, funct3, addr and wdata, then go to ACCESS; if the request is invalid, it SHALL go to RESP with the error flag set.
REQ-019 ACCESS: mem_addr SHALL be driven from the latched address; a load SHALL capture the extracted lane of mem_rd, then go to RESP.
REQ-020 ACCESS, SW: mem_we=1 with mem_wd = wdata, then RESP.
REQ-021 ACCESS, SB/SH: mem_rd SHALL be registered, then WRITE.
REQ-022 WRITE: mem_we=1, mem_wd = stored word with the addressed byte (addr[1:0]) or halfword (addr[1]) lane replaced by wdata[7:0]/[15:0], then RESP.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; no response back-pressure.
REQ-024 Latency from accept edge to rsp_valid high: loads and SW 2 cycles, SB/SH 3 cycles, errors 1 cycle.
REQ-025 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL return the whole word.
REQ-026 Loads with funct3 3/6/7, and stores with funct3 other than 0/1/2, SHALL be invalid: rsp_err=1, rsp_rdata=0, no mem_we.
REQ-027 mem_we SHALL never be high outside ACCESS/WRITE; it SHALL be high for at most one cycle per request.
REQ-028 Address bits above DEPTH_LOG2+1 SHALL be ignored; accesses wrap modulo memory size.
REQ-029 Outside ACCESS/WRITE, mem_addr SHALL hold the latched address and mem_wd SHALL be 0.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and set req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0 and mem_we=0, regardless of the clock.
REQ-031 rst asserted mid-request SHALL abandon the request with no response; a write not yet clocked SHALL NOT occur.
REQ-032 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1, or word with addr[1:0]!=0, SHALL be invalid per REQ-018/REQ-026.
REQ-034 Macro LSU_MISALIGN_TRAP_EN undefined: offending low address bits SHALL be treated as 0 and the access SHALL complete normally.

Verification
REQ-035 mem[5]=32'h8000_00F0; LB addr 0x14 -> rsp_rdata=32'hFFFF_FFF0 two cycles after accept, rsp_err=0.
REQ-036 mem[5]=32'h1234_5678; SB addr 0x16 wdata 0xAB -> one mem_we pulse, word 5 = 32'h12AB_5678, rsp_valid three cycles after accept.
REQ-037 SW addr 0x20 wdata 32'hDEAD_BEEF, then LHU addr 0x22 -> rsp_rdata=32'h0000_DEAD.
REQ-038 LW addr 0x21: with macro -> rsp_err=1, rsp_valid one cycle after accept, no mem_we; without macro -> returns word 8.
REQ-039 rst pulse while in WRITE of an SH -> mem_we never pulses, memory unchanged, no rsp_valid; req_ready=1 while in reset.
REQ-040 Back-to-back req_valid held high -> each request accepted only in IDLE, exactly one rsp_valid per accepted request, funct3=3 load -> rsp_err=1.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a word-wide data memory.
// LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word accesses are rejected.
module load_store_unit #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   output logic [1:0]  state_dbg
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; rsp_valid is a single-cycle pulse, never stalled.
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

   state_t                  state, state_n;
   logic                    we_q;
   logic [2:0]              f3_q;
   logic [DEPTH_LOG2+1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic [31:0]             word_q;
   logic [31:0]             rdata_q;
   logic                    err_q;
   logic                    req_invalid;
   logic [7:0]              byte_v;
   logic [15:0]             half_v;
   logic [31:0]             load_val;
   logic [31:0]             merged;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

   always_comb begin
      req_invalid = 1'b0;
      if (req_we)
         req_invalid = (req_funct3 > 3'd2);
      else
         req_invalid = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((req_funct3[1:0] == 2'd1) && req_addr[0])
         req_invalid = 1'b1;
      if ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0))
         req_invalid = 1'b1;
`endif
   end

   // Lane selection ignores address bits below the access size, so unaligned
   // addresses collapse onto the aligned lane when trapping is disabled.
   always_comb begin
      byte_v = mem_rd[{addr_q[1:0], 3'b000} +: 8];
      half_v = mem_rd[{addr_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'd0:    load_val = {{24{byte_v[7]}}, byte_v};
         3'd1:    load_val = {{16{half_v[15]}}, half_v};
         3'd2:    load_val = mem_rd;
         3'd4:    load_val = {24'd0, byte_v};
         3'd5:    load_val = {16'd0, half_v};
         default: load_val = 32'd0;
      endcase
   end

   always_comb begin
      merged = word_q;
      if (f3_q[1:0] == 2'd0)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      mem_addr = 32'd0;
      mem_addr[DEPTH_LOG2-1:0] = addr_q[DEPTH_LOG2+1:2];
   end

   always_comb begin
      state_n = state;
      mem_we  = 1'b0;
      mem_wd  = 32'd0;
      case (state)
         IDLE: begin
            if (req_valid)
               state_n = req_invalid ? RESP : ACCESS;
         end
         ACCESS: begin
            if (!we_q) begin
               state_n = RESP;
            end else if (f3_q == 3'd2) begin
               mem_we  = 1'b1;
               mem_wd  = wdata_q;
               state_n = RESP;
            end else begin
               state_n = WRITE;
            end
         end
         WRITE: begin
            mem_we  = 1'b1;
            mem_wd  = merged;
            state_n = RESP;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr[DEPTH_LOG2+1:0];
                  wdata_q <= req_wdata;
                  err_q   <= req_invalid;
                  rdata_q <= 32'd0;
               end
            end
            ACCESS: begin
               word_q <= mem_rd;
               if (!we_q)
                  rdata_q <= load_val;
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_err   = (state == RESP) && err_q;
   assign rsp_rdata = (state == RESP) ? rdata_q : 32'd0;
   assign state_dbg = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
// Expectations depend on LSU_MISALIGN_TRAP_EN where misalignment is exercised.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic [1:0]  state_dbg;

   logic [31:0] mem [0:1023];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_idx = 10'd0;
   logic [31:0] pre_val = 32'd0;

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   int rsp_cnt = 0;
   logic sb_on = 1'b0;
   logic [32:0] exp_q[$];

   load_store_unit #(.DEPTH_LOG2(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .state_dbg(state_dbg)
   );

   // clock / memory / monitors
   always #5 clk = ~clk;

   assign mem_rd = mem[mem_addr[9:0]];

   always @(posedge clk) begin
      if (mem_we)
         mem[mem_addr[9:0]] <= mem_wd;
      else if (pre_we)
         mem[pre_idx] <= pre_val;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we)
         we_cnt++;
      if (rsp_valid) begin
         rsp_cnt++;
         if (sb_on) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               check("sb_err", {31'd0, rsp_err}, {31'd0, e[32]});
               check("sb_rdata", rsp_rdata, e[31:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_idx = idx;
      pre_val = val;
      pre_we  = 1'b1;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic vld,
                         output logic [31:0] rdata, output logic err, output int wes);
      int w0;
      w0 = we_cnt;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(posedge clk);
         #1 lat++;
      end
      vld   = rsp_valid;
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk);
      #1 wes = we_cnt - w0;
   endtask

   task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_we);
      int lat, wes;
      logic vld, err;
      logic [31:0] rdata;
      do_req(we, f3, addr, wdata, lat, vld, rdata, err, wes);
      check({tag, "_valid"}, {31'd0, vld}, 32'd1);
      check({tag, "_rdata"}, rdata, exp_rdata);
      check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_mem_we"}, wes, exp_we);
      check({tag, "_one_shot"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   logic        bw [5];
   logic [2:0]  bf [5];
   logic [31:0] ba [5];
   logic [31:0] bd [5];

   initial begin
      int r0, n;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;

      #2;
      check("reset_ready", {31'd0, req_ready}, 32'd1);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_mem_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // sign-extended byte load
      preload(10'd5, 32'h8000_00F0);
      run_req("lb", 1'b0, 3'd0, 32'h14, 32'd0, 32'hFFFF_FFF0, 1'b0, 2, 0);

      // byte store read-modify-write
      preload(10'd5, 32'h1234_5678);
      run_req("sb", 1'b1, 3'd0, 32'h16, 32'hAB, 32'd0, 1'b0, 3, 1);
      check("sb_mem", mem[5], 32'h12AB_5678);
      check("idle_mem_wd", mem_wd, 32'd0);

      run_req("sw", 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1);
      check("sw_mem", mem[8], 32'hDEAD_BEEF);
      run_req("lhu", 1'b0, 3'd5, 32'h22, 32'd0, 32'h0000_DEAD, 1'b0, 2, 0);
      run_req("lh", 1'b0, 3'd1, 32'h20, 32'd0, 32'hFFFF_BEEF, 1'b0, 2, 0);
      run_req("lbu", 1'b0, 3'd4, 32'h23, 32'd0, 32'h0000_00DE, 1'b0, 2, 0);
      run_req("sh", 1'b1, 3'd1, 32'h22, 32'hFFFF_1234, 32'd0, 1'b0, 3, 1);
      check("sh_mem", mem[8], 32'h1234_BEEF);
      run_req("lw", 1'b0, 3'd2, 32'h20, 32'd0, 32'h1234_BEEF, 1'b0, 2, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      run_req("lw_mis", 1'b0, 3'd2, 32'h21, 32'd0, 32'd0, 1'b1, 1, 0);
      run_req("lh_mis", 1'b0, 3'd1, 32'h21, 32'd0, 32'd0, 1'b1, 1, 0);
`else
      run_req("lw_mis", 1'b0, 3'd2, 32'h21, 32'd0, 32'h1234_BEEF, 1'b0, 2, 0);
      run_req("lh_mis", 1'b0, 3'd1, 32'h21, 32'd0, 32'hFFFF_BEEF, 1'b0, 2, 0);
`endif

      // upper address bits wrap
      run_req("lw_wrap", 1'b0, 3'd2, 32'h1000_1014, 32'd0, 32'h12AB_5678, 1'b0, 2, 0);
      check("idle_mem_addr", mem_addr, 32'd5);

      run_req("bad_store", 1'b1, 3'd4, 32'h14, 32'h55, 32'd0, 1'b1, 1, 0);
      run_req("bad_load", 1'b0, 3'd6, 32'h14, 32'd0, 32'd0, 1'b1, 1, 0);
      check("bad_store_mem", mem[5], 32'h12AB_5678);

      // reset while an SH sits in WRITE
      preload(10'd9, 32'hAAAA_5555);
      r0 = rsp_cnt;
      n = we_cnt;
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h24; req_wdata = 32'h7777;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 check("rst_in_write_state", {30'd0, state_dbg}, 32'd2);
      rst = 1'b1;
      #1;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, 32'd0);
      repeat (2) @(posedge clk);
      #1 check("rst_hold_ready", {31'd0, req_ready}, 32'd1);
      check("rst_no_rsp", rsp_cnt - r0, 32'd0);
      check("rst_no_we", we_cnt - n, 32'd0);
      check("rst_mem_unchanged", mem[9], 32'hAAAA_5555);

      // accepted on the first edge after reset release
      @(negedge clk);
      rst = 1'b0;
      req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h24; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("post_rst_accept", {30'd0, state_dbg}, 32'd1);
      @(posedge clk);
      #1 check("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
      check("post_rst_rdata", rsp_rdata, 32'hAAAA_5555);
      @(posedge clk);
      #1;

      // back-to-back with req_valid held high
      bw[0] = 1'b0; bf[0] = 3'd2; ba[0] = 32'h20; bd[0] = 32'd0;
      bw[1] = 1'b0; bf[1] = 3'd3; ba[1] = 32'h20; bd[1] = 32'd0;
      bw[2] = 1'b0; bf[2] = 3'd4; ba[2] = 32'h14; bd[2] = 32'd0;
      bw[3] = 1'b1; bf[3] = 3'd0; ba[3] = 32'h15; bd[3] = 32'hCD;
      bw[4] = 1'b0; bf[4] = 3'd2; ba[4] = 32'h14; bd[4] = 32'd0;
      exp_q.push_back({1'b0, 32'h1234_BEEF});
      exp_q.push_back({1'b1, 32'd0});
      exp_q.push_back({1'b0, 32'h0000_0078});
      exp_q.push_back({1'b0, 32'd0});
      exp_q.push_back({1'b0, 32'h12AB_CD78});
      sb_on = 1'b1;
      r0 = rsp_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_we = bw[i]; req_funct3 = bf[i]; req_addr = ba[i]; req_wdata = bd[i];
         req_valid = 1'b1;
         n = 0;
         while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("b2b_ready_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
         @(posedge clk);
         #1 check("b2b_left_idle", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("b2b_rsp_count", rsp_cnt - r0, 32'd5);
      check("b2b_queue_drained", exp_q.size(), 32'd0);
      check("b2b_sb_mem", mem[5], 32'h12AB_CD78);
      sb_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
